// File: rtl/tdc_thermo_decoder.sv
// Three-stage thermometer-to-binary decoder for the TDC fine-time path:
// polarity fix, 3-tap majority bubble correction, popcount plus error flags.
module tdc_thermo_decoder #(
  parameter int NTAPS         = 32,
  parameter int OUT_WIDTH     = 6,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NTAPS-1:0]         therm_in,
  input  logic                     valid_in,
  input  logic                     invert,
  input  logic                     clr_err,
  output logic [OUT_WIDTH-1:0]     bin_out,
  output logic                     valid_out,
  output logic                     bubble_err,
  output logic                     overflow,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  logic [NTAPS-1:0]         t_d, t_q;
  logic [NTAPS-1:0]         c_d, c_q;
  logic [NTAPS+1:0]         ext_s;
  logic [NTAPS-1:0]         corr_s;
  logic                     v1_d, v1_q, v2_d, v2_q;
  logic                     diff_d, diff_q;
  logic [OUT_WIDTH-1:0]     bin_d, bin_q;
  logic                     vout_d, vout_q;
  logic                     berr_d, berr_q;
  logic                     ovf_d, ovf_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_d, cnt_q;

  function automatic logic [OUT_WIDTH-1:0] popcount(input logic [NTAPS-1:0] v);
    logic [OUT_WIDTH-1:0] n;
    n = {OUT_WIDTH{1'b0}};
    for (int i = 0; i < NTAPS; i++) begin
      n = n + OUT_WIDTH'(v[i]);
    end
    return n;
  endfunction

  // Stage 1: normalise polarity so ones always mark taps the edge has passed
  always_comb begin
    if (valid_in) begin
      t_d = therm_in ^ {NTAPS{invert}};
    end else begin
      t_d = t_q;
    end
    v1_d = valid_in;
  end

  // Stage 2: virtual taps pin the code ends (tap -1 fired, tap NTAPS not yet)
  always_comb begin
    ext_s = {1'b0, t_q, 1'b1};
    for (int i = 0; i < NTAPS; i++) begin
      corr_s[i] = (ext_s[i] & ext_s[i+1]) | (ext_s[i] & ext_s[i+2]) |
                  (ext_s[i+1] & ext_s[i+2]);
    end
    if (v1_q) begin
      c_d    = corr_s;
      diff_d = |(corr_s ^ t_q);
    end else begin
      c_d    = c_q;
      diff_d = diff_q;
    end
    v2_d = v1_q;
  end

  // Stage 3: bin, flags and the saturating bubble counter (clear wins)
  always_comb begin
    if (v2_q) begin
      bin_d  = popcount(c_q);
      ovf_d  = &c_q;
      berr_d = diff_q;
    end else begin
      bin_d  = bin_q;
      ovf_d  = ovf_q;
      berr_d = berr_q;
    end
    vout_d = v2_q;
    if (clr_err) begin
      cnt_d = {ERR_CNT_WIDTH{1'b0}};
    end else if (v2_q && diff_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q    <= {NTAPS{1'b0}};
      v1_q   <= 1'b0;
      c_q    <= {NTAPS{1'b0}};
      diff_q <= 1'b0;
      v2_q   <= 1'b0;
      bin_q  <= {OUT_WIDTH{1'b0}};
      ovf_q  <= 1'b0;
      berr_q <= 1'b0;
      vout_q <= 1'b0;
      cnt_q  <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      t_q    <= t_d;
      v1_q   <= v1_d;
      c_q    <= c_d;
      diff_q <= diff_d;
      v2_q   <= v2_d;
      bin_q  <= bin_d;
      ovf_q  <= ovf_d;
      berr_q <= berr_d;
      vout_q <= vout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bin_out    = bin_q;
  assign valid_out  = vout_q;
  assign bubble_err = berr_q;
  assign overflow   = ovf_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Randomised and directed bench for tdc_thermo_decoder against a
// tap-by-tap majority/popcount reference delayed by the pipeline depth.
module tb_tdc_thermo_decoder;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] therm_in;
  logic        valid_in, invert, clr_err;
  logic [5:0]  bin_out, bin2;
  logic        valid_out, bubble_err, overflow;
  logic        vout2, berr2, ovf2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [5:0] bin;
    logic       bub;
    logic       ovf;
  } smp_t;

  smp_t        dl[3];
  logic        e_v, e_bub, e_ovf;
  logic [5:0]  e_bin;
  logic [15:0] e_cnt;
  logic [1:0]  e_cnt2;

  tdc_thermo_decoder #(.NTAPS(32), .OUT_WIDTH(6), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .therm_in(therm_in), .valid_in(valid_in),
    .invert(invert), .clr_err(clr_err), .bin_out(bin_out),
    .valid_out(valid_out), .bubble_err(bubble_err), .overflow(overflow),
    .err_cnt(err_cnt)
  );

  tdc_thermo_decoder #(.NTAPS(32), .OUT_WIDTH(6), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .therm_in(therm_in), .valid_in(valid_in),
    .invert(invert), .clr_err(clr_err), .bin_out(bin2),
    .valid_out(vout2), .bubble_err(berr2), .overflow(ovf2),
    .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decode one sample straight from the correction rules.
  function automatic smp_t ref_model(input logic [31:0] th, input logic inv, input logic v);
    logic [31:0] t;
    int          n, a, b, c, ci;
    smp_t        s;
    t = inv ? ~th : th;
    n = 0;
    s.bub = 1'b0;
    for (int i = 0; i < N; i++) begin
      a  = (i == 0) ? 1 : int'(t[i-1]);
      b  = int'(t[i]);
      c  = (i == N-1) ? 0 : int'(t[i+1]);
      ci = ((a + b + c) >= 2) ? 1 : 0;
      n += ci;
      if (ci != b) s.bub = 1'b1;
    end
    s.v   = v;
    s.bin = 6'(n);
    s.ovf = (n == N);
    return s;
  endfunction

  function automatic logic [31:0] thermo(input int n);
    logic [63:0] w;
    w = (64'd1 << n) - 64'd1;
    return w[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) dl[i] = '{1'b0, 6'd0, 1'b0, 1'b0};
    e_v = 1'b0; e_bin = 6'd0; e_bub = 1'b0; e_ovf = 1'b0;
    e_cnt = 16'd0; e_cnt2 = 2'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  {31'd0, valid_out},  {31'd0, e_v});
    chk({tag, ".bin"},    {26'd0, bin_out},    {26'd0, e_bin});
    chk({tag, ".bubble"}, {31'd0, bubble_err}, {31'd0, e_bub});
    chk({tag, ".ovf"},    {31'd0, overflow},   {31'd0, e_ovf});
    chk({tag, ".cnt"},    {16'd0, err_cnt},    {16'd0, e_cnt});
    chk({tag, ".cnt2"},   {30'd0, err_cnt2},   {30'd0, e_cnt2});
    chk({tag, ".valid2"}, {31'd0, vout2},      {31'd0, e_v});
    chk({tag, ".bin2"},   {26'd0, bin2},       {26'd0, e_bin});
  endtask

  // One clock: drive, advance the 3-deep reference delay line, check at negedge.
  task automatic cyc(input string tag, input logic [31:0] th, input logic vin,
                     input logic inv, input logic clr);
    therm_in = th; valid_in = vin; invert = inv; clr_err = clr;
    @(posedge clk);
    dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = ref_model(th, inv, vin);
    e_v = dl[2].v;
    if (dl[2].v) begin
      e_bin = dl[2].bin; e_bub = dl[2].bub; e_ovf = dl[2].ovf;
    end
    if (rst || clr) begin
      e_cnt = 16'd0; e_cnt2 = 2'd0;
    end else if (dl[2].v && dl[2].bub) begin
      if (e_cnt != 16'hFFFF) e_cnt++;
      if (e_cnt2 != 2'b11) e_cnt2++;
    end
    if (rst) model_reset();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] base;
    logic        inv, vin, clr;
    int          sel;

    rst = 1'b1; therm_in = 32'd0; valid_in = 1'b0; invert = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    cyc("zero", 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc("zero_out", 32'h0, 1'b0, 1'b0, 1'b0);
    cyc("ff", 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    cyc("fb", 32'h0000_00FB, 1'b1, 1'b0, 1'b0);
    cyc("all1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    cyc("inv", 32'hFFFF_FF00, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc("drain", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("fb_cnt", {16'd0, err_cnt}, 32'd1);

    for (int k = 1; k <= 32; k++) begin
      cyc("stream", thermo(k), 1'b1, 1'b0, 1'b0);
      if (k == 20) cyc("gap", 32'h0, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) cyc("drain", 32'h0, 1'b0, 1'b0, 1'b0);

    // Saturation of the 2-bit counter, then clear against a bubbled sample.
    for (int k = 0; k < 5; k++) cyc("sat", 32'h0000_00FB, 1'b1, 1'b0, 1'b0);
    cyc("sat", 32'h0, 1'b0, 1'b0, 1'b0);
    cyc("sat", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt2", {30'd0, err_cnt2}, 32'd3);
    cyc("clr", 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt2", {30'd0, err_cnt2}, 32'd0);

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) cyc("flight", 32'h0000_0F7F, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_cnt", {16'd0, err_cnt}, 32'd0);
    model_reset();
    cyc("in_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) cyc("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    cyc("post_rst", 32'h0000_000F, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 400; r++) begin
      sel  = $urandom_range(0, 3);
      base = thermo($urandom_range(0, 32));
      if (sel == 1) base[$urandom_range(0, 31)] ^= 1'b1;
      else if (sel == 2) base = $urandom;
      else if (sel == 3) begin
        int p;
        p = $urandom_range(0, 30);
        base[p] ^= 1'b1; base[p+1] ^= 1'b1;
      end
      inv = 1'($urandom_range(0, 1));
      vin = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      cyc("rand", inv ? ~base : base, vin, inv, clr);
    end
    repeat (3) cyc("drain", 32'h0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
